// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module      : gshare_predictor
// Description : Global-history (gshare) branch direction predictor. A global
//               history register (GHR) is XORed with the fetch PC to index a
//               pattern history table (PHT) of 2-bit saturating counters.
//               Lookup is combinational in IF. Training happens from resolved
//               conditional branches in EX/MEM, using the index that the
//               pipeline carried with the instruction.
// Ports       : clk            - clock, all state updates on the rising edge
//               rst            - synchronous active-high reset
//               stall          - pipeline stall, freezes PHT and GHR
//               if_pc          - fetch PC to predict for
//               gl_br_dir      - predicted direction (1 = taken)
//               gl_idx         - PHT index used for the prediction
//               ex_mem_gl_idx  - index carried with the resolving branch
//               ex_mem_br_en   - resolved outcome (1 = taken)
//               ex_mem_opcode  - opcode of the EX/MEM instruction
//               ghr            - current global history (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_predictor #(
  parameter int IDX_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [31:0]          if_pc,
  output logic                 gl_br_dir,
  output logic [IDX_WIDTH-1:0] gl_idx,
  input  logic [IDX_WIDTH-1:0] ex_mem_gl_idx,
  input  logic                 ex_mem_br_en,
  input  logic [6:0]           ex_mem_opcode,
  output logic [IDX_WIDTH-1:0] ghr
);

  localparam int         c_ENTRIES   = 1 << IDX_WIDTH;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [1:0] c_CTR_RESET = 2'b01;

  // PHT is held in flops because the lookup is an asynchronous read.
  logic [1:0]           r_pht [c_ENTRIES];
  logic [IDX_WIDTH-1:0] r_ghr;

  logic                 w_upd;
  logic [IDX_WIDTH-1:0] w_idx;
  logic [1:0]           w_ctr_cur;
  logic [1:0]           w_ctr_next;

  // PC bits outside the index window do not take part in the lookup.
  logic                 w_unused_pc_bits;
  assign w_unused_pc_bits = ^{if_pc[31:IDX_WIDTH+2], if_pc[1:0]};

  // Only conditional branches train; stall blocks every state change.
  assign w_upd = (ex_mem_opcode == c_OP_BRANCH) && !stall;

  // Lookup: no bypass, so a same-cycle write to this index is not seen yet.
  assign w_idx     = if_pc[IDX_WIDTH+1:2] ^ r_ghr;
  assign gl_idx    = w_idx;
  assign gl_br_dir = r_pht[w_idx][1];
  assign ghr       = r_ghr;

  // Saturating counter step for the entry being trained.
  assign w_ctr_cur = r_pht[ex_mem_gl_idx];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (ex_mem_br_en) begin
      if (w_ctr_cur != 2'b11) begin
        w_ctr_next = w_ctr_cur + 2'b01;
      end
    end else begin
      if (w_ctr_cur != 2'b00) begin
        w_ctr_next = w_ctr_cur - 2'b01;
      end
    end
  end

  // Reset takes priority over any update presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_ENTRIES; i++) begin
        r_pht[i] <= c_CTR_RESET;
      end
    end else if (w_upd) begin
      r_pht[ex_mem_gl_idx] <= w_ctr_next;
    end
  end

  // Newest outcome enters at the LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (w_upd) begin
      r_ghr <= {r_ghr[IDX_WIDTH-2:0], ex_mem_br_en};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_gshare_predictor
// Description : Self-checking bench for gshare_predictor. A behavioural model
//               (integer counters and a history value) is checked against the
//               DUT outputs on every falling edge; directed sequences add
//               literal expectations, followed by a random traffic phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gshare_predictor;

  localparam int         IDX_WIDTH = 8;
  localparam logic [6:0] c_OP_BR   = 7'b1100011;
  localparam logic [6:0] c_OP_JAL  = 7'b1101111;
  localparam logic [6:0] c_OP_JALR = 7'b1100111;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 stall = 1'b0;
  logic [31:0]          if_pc = 32'h0;
  logic                 gl_br_dir;
  logic [IDX_WIDTH-1:0] gl_idx;
  logic [IDX_WIDTH-1:0] ex_mem_gl_idx = '0;
  logic                 ex_mem_br_en = 1'b0;
  logic [6:0]           ex_mem_opcode = 7'h0;
  logic [IDX_WIDTH-1:0] ghr;

  int checks   = 0;
  int failures = 0;

  gshare_predictor #(.IDX_WIDTH(IDX_WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .if_pc         (if_pc),
    .gl_br_dir     (gl_br_dir),
    .gl_idx        (gl_idx),
    .ex_mem_gl_idx (ex_mem_gl_idx),
    .ex_mem_br_en  (ex_mem_br_en),
    .ex_mem_opcode (ex_mem_opcode),
    .ghr           (ghr)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int   m_ctr [256];   // counter value 0..3
  int   m_hist;        // history as an integer, newest outcome in bit 0
  bit   m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) m_ctr[i] = 1;
      m_hist  = 0;
      m_valid = 1'b1;
    end else if (ex_mem_opcode == c_OP_BR && !stall) begin
      if (ex_mem_br_en) m_ctr[ex_mem_gl_idx] = (m_ctr[ex_mem_gl_idx] < 3) ? m_ctr[ex_mem_gl_idx] + 1 : 3;
      else              m_ctr[ex_mem_gl_idx] = (m_ctr[ex_mem_gl_idx] > 0) ? m_ctr[ex_mem_gl_idx] - 1 : 0;
      m_hist = ((m_hist * 2) + (ex_mem_br_en ? 1 : 0)) % 256;
    end
  end

  function automatic int exp_idx(logic [31:0] pc);
    return ((pc / 4) % 256) ^ m_hist;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cmp_ghr", {24'h0, ghr}, m_hist);
      chk("cmp_idx", {24'h0, gl_idx}, exp_idx(if_pc));
      chk("cmp_dir", {31'h0, gl_br_dir}, (m_ctr[exp_idx(if_pc)] >= 2) ? 1 : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_mem_opcode = 7'h13;
    ex_mem_br_en  = 1'b0;
    ex_mem_gl_idx = '0;
    stall         = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic upd(input logic [7:0] idx, input logic taken);
    ex_mem_opcode = c_OP_BR;
    ex_mem_gl_idx = idx;
    ex_mem_br_en  = taken;
    tick();
    idle();
  endtask

  // Point the fetch PC at a chosen PHT index under the current history.
  task automatic pc_for(input logic [7:0] idx);
    logic [7:0] h;
    h     = m_hist[7:0];
    if_pc = 32'h6000_0000 | {22'h0, idx ^ h, 2'b00};
    #1;
  endtask

  initial begin
    idle();

    // 1. reset defaults
    rst = 1'b1;
    repeat (5) tick();
    if_pc = 32'h6000_0010;
    #1;
    chk("rst_ghr", {24'h0, ghr}, 32'h00);
    chk("rst_idx", {24'h0, gl_idx}, 32'h04);
    chk("rst_dir", {31'h0, gl_br_dir}, 32'h0);
    rst = 1'b0;
    tick();

    // 2. single taken update
    upd(8'h05, 1'b1);
    if_pc = 32'h6000_0010;
    #1;
    chk("t2_ghr", {24'h0, ghr}, 32'h01);
    chk("t2_idx", {24'h0, gl_idx}, 32'h05);
    chk("t2_dir", {31'h0, gl_br_dir}, 32'h1);
    chk("t2_model_ctr", m_ctr[5], 2);

    // 3. saturation and hysteresis
    do_reset();
    repeat (3) upd(8'h05, 1'b1);
    chk("t3_model_ctr11", m_ctr[5], 3);
    pc_for(8'h05);
    chk("t3_dir_after3t", {31'h0, gl_br_dir}, 32'h1);
    upd(8'h05, 1'b0);
    chk("t3_model_ctr10", m_ctr[5], 2);
    pc_for(8'h05);
    chk("t3_dir_hyst", {31'h0, gl_br_dir}, 32'h1);
    upd(8'h05, 1'b0);
    pc_for(8'h05);
    chk("t3_dir_ctr01", {31'h0, gl_br_dir}, 32'h0);
    repeat (2) upd(8'h05, 1'b0);
    chk("t3_model_ctr00", m_ctr[5], 0);
    upd(8'h05, 1'b0);
    chk("t3_model_ctr00_hold", m_ctr[5], 0);
    // one taken from 00 must still predict not-taken (00 -> 01)
    upd(8'h05, 1'b1);
    pc_for(8'h05);
    chk("t3_dir_from00", {31'h0, gl_br_dir}, 32'h0);

    // 4. filtering
    do_reset();
    ex_mem_opcode = c_OP_JAL; ex_mem_gl_idx = 8'h05; ex_mem_br_en = 1'b1;
    tick();
    ex_mem_opcode = c_OP_JALR;
    tick();
    idle();
    pc_for(8'h05);
    chk("t4_jal_ghr", {24'h0, ghr}, 32'h00);
    chk("t4_jal_dir", {31'h0, gl_br_dir}, 32'h0);
    ex_mem_opcode = c_OP_BR; ex_mem_gl_idx = 8'h05; ex_mem_br_en = 1'b1; stall = 1'b1;
    repeat (3) tick();
    chk("t4_stall_ghr", {24'h0, ghr}, 32'h00);
    if_pc = 32'h6000_0014;
    #1;
    chk("t4_stall_dir", {31'h0, gl_br_dir}, 32'h0);
    chk("t4_stall_idx_comb", {24'h0, gl_idx}, 32'h05);
    stall = 1'b0;
    tick();
    idle();
    tick();
    chk("t4_once_ghr", {24'h0, ghr}, 32'h01);
    pc_for(8'h05);
    chk("t4_once_dir", {31'h0, gl_br_dir}, 32'h1);
    chk("t4_once_model", m_ctr[5], 2);

    // 5. history shift
    do_reset();
    repeat (8) upd(8'h00, 1'b1);
    chk("t5_ghr_ff", {24'h0, ghr}, 32'hFF);
    upd(8'h00, 1'b0);
    chk("t5_ghr_fe", {24'h0, ghr}, 32'hFE);

    // 6. reset priority over a simultaneous update
    do_reset();
    repeat (3) upd(8'h05, 1'b1);
    pc_for(8'h05);
    chk("t6_pre_dir", {31'h0, gl_br_dir}, 32'h1);
    rst = 1'b1;
    ex_mem_opcode = c_OP_BR; ex_mem_gl_idx = 8'h05; ex_mem_br_en = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("t6_ghr", {24'h0, ghr}, 32'h00);
    for (int i = 0; i < 256; i++) begin
      if_pc = i * 4;
      #1;
      chk("t6_all_dir", {31'h0, gl_br_dir}, 32'h0);
      chk("t6_all_idx", {24'h0, gl_idx}, i);
    end
    tick();

    // random traffic, checked by the model compare process
    for (int n = 0; n < 2000; n++) begin
      rst           = ($urandom_range(0, 199) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 7))
        0:       ex_mem_opcode = c_OP_JAL;
        1:       ex_mem_opcode = c_OP_JALR;
        2:       ex_mem_opcode = 7'($urandom);
        default: ex_mem_opcode = c_OP_BR;
      endcase
      // narrow index range half the time so counters reach saturation
      ex_mem_gl_idx = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      ex_mem_br_en  = 1'($urandom);
      if_pc         = ($urandom_range(0, 1) == 0) ? {22'h0, 8'($urandom_range(0, 7)) ^ m_hist[7:0], 2'b00} : $urandom;
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/gshare_predictor.md
# gshare_predictor

Global-history branch predictor feeding the `gl_br_dir` input of the tournament predictor. Holds a global history register (GHR) and a pattern history table (PHT) of 2-bit saturating counters indexed by fetch PC XOR GHR. Predicts combinationally in IF. Trains non-speculatively from resolved branches in EX/MEM, using the index the pipeline carried with the instruction.

## Interface
Parameters:
- `IDX_WIDTH`, 8, PHT index width and GHR width; the PHT has 2^IDX_WIDTH entries.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  reset: synchronous, active-high
- `stall`  in  1  pipeline stall; blocks all state updates while high
- `if_pc`  in  32  fetch PC to predict for
- `gl_br_dir`  out  1  predicted direction for `if_pc` (1 = taken); to the tournament predictor
- `gl_idx`  out  IDX_WIDTH  PHT index used for this prediction; the pipeline carries it to EX/MEM
- `ex_mem_gl_idx`  in  IDX_WIDTH  index carried with the resolving instruction
- `ex_mem_br_en`  in  1  resolved branch outcome (1 = taken)
- `ex_mem_opcode`  in  7  opcode of the EX/MEM instruction
- `ghr`  out  IDX_WIDTH  current global history, for debug and verification

## Operation
- Lookup is purely combinational:
  - `gl_idx = if_pc[IDX_WIDTH+1:2] ^ ghr`
  - `gl_br_dir = pht[gl_idx][1]`
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- The update enable `upd` is high when `ex_mem_opcode == 7'b1100011` and `!stall`. Only conditional branches train; JAL, JALR and all other opcodes are ignored.
- When `upd` is high, the following happens on the rising edge:
  - `pht[ex_mem_gl_idx]` increments, saturating at 11, if `ex_mem_br_en` = 1.
  - Otherwise it decrements, saturating at 00.
  - `ghr <= {ghr[IDX_WIDTH-2:0], ex_mem_br_en}`, so the newest outcome sits in the LSB.
- When `upd` is low, the PHT and GHR hold their values.
- On reset:
  - Every PHT entry is set to 01, so all entries predict not-taken.
  - `ghr` is set to 0.
  - Reset has priority over any simultaneous update.
- Reset asserted mid-operation discards all training on the next edge. Any update presented in that cycle is dropped.
- The PHT must be implemented as flops, not SRAM, because the read is asynchronous.
- Target size is roughly 150 lines of RTL.

## Timing
- Prediction has zero-cycle latency: `gl_br_dir` and `gl_idx` follow `if_pc` and `ghr` within the same cycle.
- Update-to-visibility is one cycle. An update at edge N is visible to lookups in the cycle after edge N.
- Same-cycle read and write to the same index returns the pre-update counter value. There is no write-to-read bypass.
- The GHR shift at edge N changes `gl_idx` for the current `if_pc` from cycle N onward.
- `stall` freezes both the PHT and the GHR for every cycle it is high. Lookup outputs stay combinational during a stall.
- Output values after reset, for any `if_pc`:
  - `ghr` = 0
  - `gl_idx` = `if_pc[IDX_WIDTH+1:2]`
  - `gl_br_dir` = 0
- Index width: `if_pc` bits [1:0] are ignored. There is no wrap handling beyond the natural IDX_WIDTH truncation.

## Test plan
1. **Reset defaults:** hold `rst` for 5 cycles, then drive `if_pc`=0x60000010.
   - Required: `ghr`=0x00, `gl_idx`=0x04, `gl_br_dir`=0.
2. **Single taken update:** opcode 7'b1100011, `ex_mem_gl_idx`=0x05, `br_en`=1, `stall`=0, for one cycle.
   - Required next cycle: `ghr`=0x01. With `if_pc`=0x60000010: `gl_idx`=0x05, `gl_br_dir`=1.
3. **Saturation and hysteresis:**
   - Step 1: after reset, give 3 taken updates to idx 0x05. The counter must read 11.
   - Step 2: give 1 not-taken update. The counter must read 10 and still predict 1.
   - Step 3: give 3 more not-taken updates. The counter must read 00, then stay at 00 on a 4th.
4. **Filtering:**
   - opcode 7'b1101111 with `br_en`=1 → PHT and `ghr` unchanged.
   - opcode 7'b1100011 with `stall`=1 → PHT and `ghr` unchanged.
   - Same update after `stall` deasserts → applied once.
5. **History shift:** after reset, give 8 taken updates. Required: `ghr`=0xFF. One not-taken update then gives `ghr`=0xFE.
6. **Reset priority:** train idx 0x05 to 11, then assert `rst` in the same cycle as a taken update.
   - Required next cycle: `ghr`=0x00, all counters 01, `gl_br_dir`=0 for every idx.
   - Bench requirement: compare against a reference-model class over 2000 random update/lookup cycles with zero mismatches.
